// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//   Shares the single write port of one FIFO among NUM_REQ producers.
//   Round-robin selection with burst locking: the chosen producer owns the
//   port for up to MAX_BURST beats (or until it drops valid), then the grant
//   rotates. The requester that just released becomes lowest priority.
//   Each new grant costs one arbitration cycle in IDLE with no transfer.
//   Data path is combinational: producer data reaches the FIFO in the same
//   cycle as the valid/ready handshake.
//
// Ports
//   clk           clock, rising edge
//   rst_n         asynchronous active-low reset
//   req_valid_i   per-producer valid
//   req_data_i    producer i data at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready_o   per-producer ready (only the owner's bit can be 1)
//   fifo_full_i   FIFO full flag
//   fifo_wren_o   FIFO write enable
//   fifo_wdata_o  FIFO write data (0 while idle)
//   grant_o       one-hot current owner, 0 while idle
//   busy_o        1 while a producer owns the port
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic                          fifo_full_i,
  output logic                          fifo_wren_o,
  output logic [DATA_WIDTH-1:0]         fifo_wdata_o,
  output logic [NUM_REQ-1:0]            grant_o,
  output logic                          busy_o
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_LOCK = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [GW-1:0] owner_q, owner_d;
  logic [GW-1:0] last_grant_q, last_grant_d;
  logic [BW-1:0] beat_cnt_q, beat_cnt_d;

  logic                  pick_found;
  logic [GW-1:0]         pick_idx;
  logic [NUM_REQ-1:0]    owner_onehot;
  logic                  owner_valid;
  logic [DATA_WIDTH-1:0] owner_data;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      owner_q      <= '0;
      last_grant_q <= GW'(NUM_REQ - 1);
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

  // Round-robin search starting just after the last owner, so the previous
  // owner is considered last.
  always_comb begin
    int cand;
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(last_grant_q) + k) % NUM_REQ;
      if (!pick_found && req_valid_i[GW'(cand)]) begin
        pick_found = 1'b1;
        pick_idx   = GW'(cand);
      end
    end
  end

  // Decode owner index into one-hot, its valid bit and its data lane.
  always_comb begin
    owner_onehot = '0;
    owner_valid  = 1'b0;
    owner_data   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_q == GW'(i)) begin
        owner_onehot[i] = 1'b1;
        owner_valid     = req_valid_i[i];
        owner_data      = req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          state_d    = S_LOCK;
          owner_d    = pick_idx;
          beat_cnt_d = '0;
        end
      end
      S_LOCK: begin
        if (!owner_valid) begin
          // Owner gave up the port; release without a transfer.
          state_d      = S_IDLE;
          last_grant_d = owner_q;
        end else if (!fifo_full_i) begin
          if (beat_cnt_q == BW'(MAX_BURST - 1)) begin
            state_d      = S_IDLE;
            last_grant_d = owner_q;
            beat_cnt_d   = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
        // Full with owner still valid: everything holds, lock kept.
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: purely gated by state and fifo_full_i, nothing latched.
  always_comb begin
    grant_o      = '0;
    req_ready_o  = '0;
    fifo_wren_o  = 1'b0;
    fifo_wdata_o = '0;
    busy_o       = 1'b0;
    if (state_q == S_LOCK) begin
      grant_o      = owner_onehot;
      req_ready_o  = fifo_full_i ? '0 : owner_onehot;
      fifo_wren_o  = owner_valid & ~fifo_full_i;
      fifo_wdata_o = owner_data;
      busy_o       = 1'b1;
    end
  end

endmodule
